// File: rtl/router_tx_if.sv
// router_tx_if: PE-side, config and array-bus signals of router_tx; master = router_tx, slave = PE/arbiter side
interface router_tx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8
);
  logic                  config_state;
  logic                  ce;
  logic [ID_WIDTH-1:0]   cfg_id;
  logic [DATA_WIDTH-1:0] pe_data_out;
  logic                  pe_data_out_en;
  logic                  pe_ready;
  logic                  bus_req;
  logic                  bus_grant;
  logic [DATA_WIDTH-1:0] bus_data_out;
  logic                  bus_data_valid;
  logic [ID_WIDTH-1:0]   bus_src_id;
  logic                  overflow;
  modport master (
    input  config_state, ce, cfg_id, pe_data_out, pe_data_out_en, bus_grant,
    output pe_ready, bus_req, bus_data_out, bus_data_valid, bus_src_id, overflow
  );
  modport slave (
    output config_state, ce, cfg_id, pe_data_out, pe_data_out_en, bus_grant,
    input  pe_ready, bus_req, bus_data_out, bus_data_valid, bus_src_id, overflow
  );
endinterface

// File: rtl/router_tx.sv
// router_tx: buffers PE result words and sends them on the array bus tagged with my_id (clk, rst, io: router_tx_if.master; ROUTER_TX_BURST_EN enables multi-word grants)
module router_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input logic          clk,
  input logic          rst,
  router_tx_if.master  io
);
  localparam int CW = FIFO_AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;
  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nx;
  logic [ID_WIDTH-1:0]   my_id;
  logic                  push, pop, empty;
  assign empty = count == '0;
  assign push = io.pe_data_out_en && io.pe_ready && !io.config_state;
`ifdef ROUTER_TX_BURST_EN
  assign pop = (state == REQ || state == SEND) && io.bus_grant && !empty && !io.config_state;
`else
  // one word per grant: only the REQ edge that sees the grant pops
  assign pop = state == REQ && io.bus_grant && !empty && !io.config_state;
`endif
  assign count_nx = count + CW'(push) - CW'(pop);
  assign io.bus_src_id = my_id;
  always_comb begin
    state_nx = state;
    if (io.config_state) state_nx = IDLE;
    else
      unique case (state)
        IDLE: state_nx = empty ? IDLE : REQ;
        REQ:  state_nx = io.bus_grant ? SEND : REQ;
`ifdef ROUTER_TX_BURST_EN
        SEND: state_nx = !io.bus_grant ? (empty ? IDLE : REQ) : (empty ? GAP : SEND);
`else
        SEND: state_nx = GAP;
`endif
        GAP:  state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= io.pe_data_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      my_id             <= '0;
      io.pe_ready       <= 1'b1;
      io.overflow       <= 1'b0;
      io.bus_req        <= 1'b0;
      io.bus_data_valid <= 1'b0;
      io.bus_data_out   <= '0;
    end else begin
      state             <= state_nx;
      count             <= count_nx;
      io.pe_ready       <= count_nx != FULL;
      io.bus_req        <= state_nx == REQ || state_nx == SEND;
      io.bus_data_valid <= pop;
      if (io.config_state && io.ce) my_id <= io.cfg_id;
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop) begin
        rd_ptr          <= rd_ptr + FIFO_AW'(1);
        io.bus_data_out <= mem[rd_ptr];
      end
      if (io.pe_data_out_en && !io.pe_ready && !io.config_state) io.overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_router_tx.sv
// tb_router_tx: randomized and directed checks of router_tx against a queue-based model
module tb_router_tx;
  localparam int DW = 16;
  localparam int IW = 8;
  localparam int DEPTH = 4;
`ifdef ROUTER_TX_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  router_tx_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) io ();
  router_tx #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
    .clk(clk),
    .rst(rst),
    .io(io.master)
  );
  int total = 0;
  int bad = 0;
  logic [DW-1:0] q[$];
  logic          ovf_m = 1'b0;
  logic [IW-1:0] id_m = '0;
  logic [DW-1:0] last_data = '0;
  logic          last_valid = 1'b0;
  int sent = 0;
  int run = 0;
  int max_run = 0;
  int gmode = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    logic          r, att, acc, cfg_ce;
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    r = rst;
    att = io.pe_data_out_en && !io.config_state;
    acc = att && q.size() < DEPTH;
    cfg_ce = io.config_state && io.ce;
    d = io.pe_data_out;
    id = io.cfg_id;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      ovf_m = 1'b0;
      id_m = '0;
      last_data = '0;
      last_valid = 1'b0;
    end else begin
      if (cfg_ce) id_m = id;
      if (acc) q.push_back(d);
      if (att && !acc) ovf_m = 1'b1;
    end
    if (io.bus_data_valid) begin
      if (q.size() == 0) chk("extra_word", 1, 0);
      else chk("word", io.bus_data_out, q.pop_front());
      chk("back_to_back", last_valid && !BURST, 0);
      sent++;
      run++;
    end else begin
      chk("hold", io.bus_data_out, last_data);
      run = 0;
    end
    if (run > max_run) max_run = run;
    last_valid = io.bus_data_valid;
    last_data = io.bus_data_out;
    chk("pe_ready", io.pe_ready, q.size() < DEPTH);
    chk("overflow", io.overflow, ovf_m);
    chk("src_id", io.bus_src_id, id_m);
    io.bus_grant = gmode == 1 ? io.bus_req :
                   gmode == 2 ? io.bus_req && ($urandom_range(1) == 1) :
                   gmode == 3 ? io.bus_grant : 1'b0;
  endtask
  task automatic push(input logic [DW-1:0] d);
    io.pe_data_out = d;
    io.pe_data_out_en = 1'b1;
    tick();
    io.pe_data_out_en = 1'b0;
  endtask
  task automatic wait_req(input int budget);
    int n = 0;
    while (!io.bus_req && n < budget) begin
      tick();
      n++;
    end
    chk("req_timeout", io.bus_req, 1);
  endtask
  task automatic drain(input int n);
    gmode = 1;
    repeat (n) tick();
    chk("drained", q.size(), 0);
  endtask
  task automatic pulse_rst;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    io.config_state = 1'b0;
    io.ce = 1'b0;
    io.cfg_id = '0;
    io.pe_data_out = '0;
    io.pe_data_out_en = 1'b0;
    io.bus_grant = 1'b0;
    tick();
    pulse_rst();
    chk("rst_req", io.bus_req, 0);
    chk("rst_valid", io.bus_data_valid, 0);
    chk("rst_data", io.bus_data_out, 0);
    chk("rst_ovf", io.overflow, 0);
    chk("rst_ready", io.pe_ready, 1);
    chk("rst_id", io.bus_src_id, 0);
    io.config_state = 1'b1;
    io.ce = 1'b1;
    io.cfg_id = 8'h2A;
    tick();
    io.config_state = 1'b0;
    io.ce = 1'b0;
    chk("cfg_id", io.bus_src_id, 8'h2A);
    gmode = 0;
    push(16'h1234);
    chk("req_at_push", io.bus_req, 0);
    tick();
    chk("req_2cyc", io.bus_req, 1);
    tick();
    chk("req_hold", io.bus_req, 1);
    chk("no_grant_valid", io.bus_data_valid, 0);
    gmode = 1;
    io.bus_grant = 1'b1;
    tick();
    chk("grant_valid", io.bus_data_valid, 1);
    chk("grant_data", io.bus_data_out, 16'h1234);
    tick();
    chk("req_drop", io.bus_req, 0);
    chk("valid_once", io.bus_data_valid, 0);
    sent = 0;
    run = 0;
    max_run = 0;
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    drain(16);
    chk("burst_sent", sent, 3);
    chk("burst_run", max_run, BURST ? 3 : 1);
    gmode = 0;
    io.pe_data_out_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      io.pe_data_out = 16'hA0 + 16'(i);
      tick();
      if (i == 3) chk("full_ready", io.pe_ready, 0);
    end
    io.pe_data_out_en = 1'b0;
    chk("full_ovf", io.overflow, 1);
    sent = 0;
    drain(30);
    chk("full_sent", sent, 4);
    pulse_rst();
    gmode = 0;
    for (int i = 0; i < 4; i++) push(16'hB0 + 16'(i));
    wait_req(10);
    gmode = 3;
    sent = 0;
    io.bus_grant = 1'b1;
    tick();
    tick();
    io.bus_grant = 1'b0;
    tick();
    tick();
    chk("drop_sent", sent, BURST ? 2 : 1);
    chk("drop_req", io.bus_req, 1);
    drain(25);
    chk("drop_total", sent, 4);
    gmode = 0;
    for (int i = 0; i < 4; i++) push(16'hC0 + 16'(i));
    wait_req(10);
    gmode = 1;
    io.bus_grant = 1'b1;
    tick();
    tick();
    pulse_rst();
    chk("mrst_req", io.bus_req, 0);
    chk("mrst_valid", io.bus_data_valid, 0);
    chk("mrst_ready", io.pe_ready, 1);
    sent = 0;
    drain(15);
    chk("mrst_none", sent, 0);
    pulse_rst();
    gmode = 2;
    for (int i = 0; i < 600; i++) begin
      io.config_state = $urandom_range(19) == 0;
      io.ce = $urandom_range(1) == 1;
      io.cfg_id = IW'($urandom);
      io.pe_data_out = DW'($urandom);
      io.pe_data_out_en = $urandom_range(2) != 0;
      tick();
    end
    io.config_state = 1'b0;
    io.ce = 1'b0;
    io.pe_data_out_en = 1'b0;
    drain(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/router_tx.md
# router_tx

Transmit-side companion to the PE array router. Buffers result words produced by a PE, requests the shared array bus, and drives each word onto the bus tagged with this PE's configured ID, so routers at the other end can match it against their own `source_id`. One instance sits between each PE's output port and the array bus arbiter.

## Interface
- `DATA_WIDTH`, 16: bus and PE data width.
- `ID_WIDTH`, 8: PE ID width.
- `FIFO_DEPTH`, 4: output buffer entries; power of two, at least 2.
- `FIFO_AW`, 2: log2(`FIFO_DEPTH`).

Ports:
- `clk`  in  1: the only clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `config_state`  in  1: array is in its configuration phase.
- `ce`  in  1: configuration strobe for this PE.
- `cfg_id`  in  `ID_WIDTH`: ID captured during configuration.
- `pe_data_out`  in  `DATA_WIDTH`: PE result word.
- `pe_data_out_en`  in  1: push strobe for `pe_data_out`.
- `pe_ready`  out  1: buffer not full.
- `bus_req`  out  1: request to the bus arbiter.
- `bus_grant`  in  1: grant from the arbiter.
- `bus_data_out`  out  `DATA_WIDTH`: word on the bus.
- `bus_data_valid`  out  1: `bus_data_out` is valid this cycle.
- `bus_src_id`  out  `ID_WIDTH`: ID tag that accompanies the word.
- `overflow`  out  1: sticky flag, set when a push is dropped.

## Operation
- **ID register.** On an edge where `config_state` and `ce` are both high, `my_id` takes `cfg_id`. `bus_src_id` always shows `my_id`. Reset value is 0.
- **FIFO.**
  - Circular buffer with `FIFO_DEPTH` entries and a count that runs from 0 to `FIFO_DEPTH`.
  - A push happens when `pe_data_out_en` is high, `pe_ready` is high and `config_state` is low.
  - A push while full is dropped and sets `overflow`. A push during `config_state` is ignored and does not set `overflow`.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
  - `pe_ready` is the registered, inverted full flag.
- **FSM states.**
  - IDLE: when the FIFO is non-empty and `config_state` is low, go to REQ.
  - REQ: when `bus_grant` is high, go to SEND.
  - SEND: the send rules below decide the next state.
  - GAP: go to IDLE.
- **Sending.** On each edge in REQ or SEND where `bus_grant` is high and the FIFO is non-empty:
  - the head word is registered into `bus_data_out`;
  - `bus_data_valid` is set to 1;
  - the head entry is popped.
  
  On any other edge, `bus_data_valid` is 0 and `bus_data_out` holds its previous value.
- **SEND exit.**
  - If `bus_grant` drops: go to REQ if the FIFO is non-empty, otherwise IDLE.
  - If the FIFO empties: go to GAP.
  - Burst behaviour is described under Configuration.
- **`bus_req`.** Registered; it is 1 exactly while the state is REQ or SEND.
- **Configuration abort.** `config_state` high in any state forces IDLE at the next edge. Any word already registered still completes its one valid cycle. FIFO contents are kept.
- **Reset.**
  - Applies in any state, including mid-burst.
  - FSM goes to IDLE and the FIFO empties.
  - `bus_req`=0, `bus_data_valid`=0, `bus_data_out`=0, `overflow`=0, `pe_ready`=1, `my_id`=0.

## Timing
- Push to `bus_req` high: 2 cycles (push edge, then the IDLE→REQ edge). `bus_req` rises together with the state change.
- Grant to data: `bus_grant` sampled high at edge N gives `bus_data_valid`=1 in the cycle after N. Each grant-high edge produces one word.
- Burst throughput: one word per cycle while granted and the FIFO is non-empty.
- `pe_ready` reflects the count after the current edge. A producer must see `pe_ready`=1 before it asserts `pe_data_out_en`.
- The arbiter must only assert `bus_grant` while `bus_req` is high. If `bus_grant` is high while `bus_req` is low, the block ignores it.

## Configuration
- Macro `ROUTER_TX_BURST_EN`.
- **Defined:** SEND keeps popping while `bus_grant` stays high and the FIFO is non-empty.
- **Undefined:**
  - Only one word is sent per grant.
  - After it, SEND always goes to GAP, which drops `bus_req` for one cycle.
  - The FSM then re-requests from IDLE if data remains, so other PEs get fair access to the bus.

## Test plan
- **Reset and ID.** Pulse reset, then `config_state`=1, `ce`=1, `cfg_id`=0x2A for one cycle → all outputs at their reset values, then `bus_src_id`=0x2A.
- **Single word.** Push 0x1234 and hold `bus_grant`=0 → `bus_req` goes high 2 cycles later. Then assert grant → one cycle with `bus_data_valid`=1 and `bus_data_out`=0x1234, then `bus_req`=0.
- **Burst of 3.** Push 0x0001, 0x0002, 0x0003 and hold grant high.
  - With `ROUTER_TX_BURST_EN`: 3 back-to-back valid cycles in order.
  - Without it: valid cycles separated by a `bus_req` low gap.
- **Full.** Push 5 words with grant held low → `pe_ready`=0 after the 4th push, the 5th push is dropped, `overflow`=1, and only the first 4 words are later sent.
- **Grant drop mid-burst.** 4 words queued; grant is high for 2 cycles then low → 2 words sent, `bus_req` stays 1, and after a re-grant the remaining 2 are sent in order.
- **Reset mid-burst.** Assert `rst` during SEND → next cycle `bus_req`=0, `bus_data_valid`=0, FIFO empty, and no further words are sent.
